subleq_run_ctrl: RTL and testbench

//  Run/step sequencer for the subleq CPU. Lives on the board clock, next to the cpu instance.

---
 rtl/subleq_pkg.sv | 22 ++
 rtl/btn_debounce.sv | 43 ++++
 rtl/subleq_run_ctrl.sv | 115 +++++++++++
 tb/tb_subleq_run_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/subleq_pkg.sv
// Shared encodings for the subleq CPU, its run controller and the LED/HEX mapping.
package subleq_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned STEP_CNT_W = 32;
  localparam int unsigned PRESC_W    = 8;

  typedef enum logic [1:0] {
    MODE_HALT = 2'b00,
    MODE_STEP = 2'b01,
    MODE_SLOW = 2'b10,
    MODE_FAST = 2'b11
  } run_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BREAK = 2'd2,
    ST_DONE  = 2'd3
  } run_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Step-key conditioner: 2-FF synchronizer, symmetric debounce, one-cycle press pulse.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_n,
  output logic o_press
);

  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       r_sync;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;

  // Synchronize, then flip the debounced level only after DEB_CYCLES disagreeing samples.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync  <= 2'b11;
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn_n};
      r_press <= 1'b0;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt   <= '0;
        r_level <= r_sync[1];
        r_press <= ~r_sync[1];
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/subleq_run_ctrl.sv
// Run/step sequencer: issues single-cycle CPU enables in halt/step/slow/fast modes,
// stops on PC breakpoint or CPU halt, and counts issued steps.
module subleq_run_ctrl #(
  parameter int unsigned ADDR_W     = subleq_pkg::ADDR_W_DEF,
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic [1:0]        iMode,
  input  logic              iStepBtn,
  input  logic [7:0]        iLimit,
  input  logic              iBreakEn,
  input  logic [ADDR_W-1:0] iBreakAddr,
  input  logic [ADDR_W-1:0] iPc,
  input  logic              iHaltReq,
  output logic              oCpuEn,
  output logic [1:0]        oState,
  output logic [31:0]       oStepCount
);

  import subleq_pkg::*;

  run_mode_e             w_mode;
  run_state_e            r_state, w_state_nxt;
  logic                  r_cpu_en, w_pulse;
  logic [STEP_CNT_W-1:0] r_step_cnt;
  logic [PRESC_W-1:0]    r_presc, w_presc_nxt;
  logic                  w_step_req;
  logic                  w_tick;
  logic                  w_bp_hit;
  logic                  w_pc_stale;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn_debounce (
    .i_clk   (iClock),
    .i_rst_n (iReset),
    .i_btn_n (iStepBtn),
    .o_press (w_step_req)
  );

  assign w_mode     = run_mode_e'(iMode);
  // Compare with >= so a lowered limit ticks at once instead of wrapping through 255.
  assign w_tick     = (r_presc >= iLimit);
  assign w_bp_hit   = iBreakEn & (iPc == iBreakAddr);
  // iPc still shows the old value in the cycle after a pulse; skip compare and pulse then.
  assign w_pc_stale = r_cpu_en & iBreakEn;

  // State, enable, step counter and prescaler registers.
  always_ff @(posedge iClock) begin
    if (!iReset) begin
      r_state    <= ST_IDLE;
      r_cpu_en   <= 1'b0;
      r_step_cnt <= '0;
      r_presc    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cpu_en   <= w_pulse;
      r_step_cnt <= r_step_cnt + STEP_CNT_W'(w_pulse);
      r_presc    <= w_presc_nxt;
    end
  end

  // Next state, pulse request and prescaler; CPU halt overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_pulse     = 1'b0;
    w_presc_nxt = '0;
    if (iHaltReq) begin
      w_state_nxt = ST_DONE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          case (w_mode)
            MODE_STEP:            w_pulse     = w_step_req & ~w_pc_stale;
            MODE_SLOW, MODE_FAST: w_state_nxt = ST_RUN;
            default:              ;
          endcase
        end
        ST_RUN: begin
          if (w_mode == MODE_HALT || w_mode == MODE_STEP) begin
            w_state_nxt = ST_IDLE;
          end else begin
            if (w_mode == MODE_SLOW) begin
              w_presc_nxt = w_tick ? '0 : r_presc + PRESC_W'(1);
            end
            if (!w_pc_stale) begin
              if (w_bp_hit) begin
                w_state_nxt = ST_BREAK;
              end else begin
                w_pulse = (w_mode == MODE_FAST) | w_tick;
              end
            end
          end
        end
        ST_BREAK: begin
          if (w_mode == MODE_HALT) begin
            w_state_nxt = ST_IDLE;
          end else if (w_step_req) begin
            // Escape pulse deliberately bypasses the breakpoint compare.
            w_pulse     = 1'b1;
            w_state_nxt = ST_RUN;
          end
        end
        ST_DONE: ;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign oCpuEn     = r_cpu_en;
  assign oState     = r_state;
  assign oStepCount = r_step_cnt;

endmodule

// File: tb/tb_subleq_run_ctrl.sv
// Directed bench for subleq_run_ctrl with a short debounce window.
module tb_subleq_run_ctrl;

  logic        iClock = 1'b0;
  logic        iReset;
  logic [1:0]  iMode;
  logic        iStepBtn;
  logic [7:0]  iLimit;
  logic        iBreakEn;
  logic [7:0]  iBreakAddr;
  logic [7:0]  iPc;
  logic        iHaltReq;
  logic        oCpuEn;
  logic [1:0]  oState;
  logic [31:0] oStepCount;

  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   n_pulse = 0;
  int   p0;
  logic pc_auto = 1'b0;

  subleq_run_ctrl #(
    .ADDR_W     (8),
    .DEB_CYCLES (4)
  ) dut (
    .iClock     (iClock),
    .iReset     (iReset),
    .iMode      (iMode),
    .iStepBtn   (iStepBtn),
    .iLimit     (iLimit),
    .iBreakEn   (iBreakEn),
    .iBreakAddr (iBreakAddr),
    .iPc        (iPc),
    .iHaltReq   (iHaltReq),
    .oCpuEn     (oCpuEn),
    .oState     (oState),
    .oStepCount (oStepCount)
  );

  always #5 iClock = ~iClock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock; sample just after the edge, count pulses, and model the CPU PC advancing.
  task automatic step_clk();
    @(posedge iClock);
    #1;
    if (oCpuEn === 1'b1) begin
      n_pulse++;
      if (pc_auto) iPc = iPc + 8'd1;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step_clk();
  endtask

  task automatic btn(input logic lvl, input int n);
    iStepBtn = lvl;
    steps(n);
  endtask

  task automatic do_reset();
    iReset = 1'b0;
    steps(2);
    iReset = 1'b1;
  endtask

  initial begin
    iReset = 1'b0; iMode = 2'b01; iStepBtn = 1'b1; iLimit = 8'd0;
    iBreakEn = 1'b0; iBreakAddr = 8'd0; iPc = 8'd0; iHaltReq = 1'b0;

    // 1: reset state and three clean presses in STEP
    do_reset();
    chk("rst_state", 32'(oState), 32'd0);
    chk("rst_en", 32'(oCpuEn), 32'd0);
    chk("rst_cnt", oStepCount, 32'd0);
    p0 = n_pulse;
    iStepBtn = 1'b0;
    steps(6);
    chk("t1_lat_before", 32'(oCpuEn), 32'd0);
    step_clk();
    chk("t1_lat_pulse", 32'(oCpuEn), 32'd1);
    step_clk();
    chk("t1_one_cycle", 32'(oCpuEn), 32'd0);
    btn(1'b1, 8);
    repeat (2) begin btn(1'b0, 8); btn(1'b1, 8); end
    chk("t1_pulses", 32'(n_pulse - p0), 32'd3);
    chk("t1_cnt", oStepCount, 32'd3);
    chk("t1_state", 32'(oState), 32'd0);

    // 2: press and release glitches give one pulse; HALT ignores presses
    p0 = n_pulse;
    btn(1'b0, 2); btn(1'b1, 2); btn(1'b0, 2); btn(1'b1, 2);
    btn(1'b0, 8);
    btn(1'b1, 2); btn(1'b0, 2); btn(1'b1, 2); btn(1'b0, 2);
    btn(1'b1, 8);
    chk("t2_glitch_pulses", 32'(n_pulse - p0), 32'd1);
    chk("t2_cnt", oStepCount, 32'd4);
    iMode = 2'b00;
    p0 = n_pulse;
    btn(1'b0, 8); btn(1'b1, 8);
    chk("t2_halt_ignore", 32'(n_pulse - p0), 32'd0);

    // 3: SLOW with limit 3, then limit dropped to 0 mid-count
    iLimit = 8'd3; iMode = 2'b10;
    p0 = n_pulse;
    steps(41);
    chk("t3_slow_pulses", 32'(n_pulse - p0), 32'd10);
    chk("t3_slow_last", 32'(oCpuEn), 32'd1);
    chk("t3_state", 32'(oState), 32'd1);
    steps(2);
    iLimit = 8'd0;
    step_clk();
    chk("t3_drop_tick", 32'(oCpuEn), 32'd1);
    steps(2);
    chk("t3_pulses_total", 32'(n_pulse - p0), 32'd13);
    chk("t3_cnt", oStepCount, 32'd17);
    iMode = 2'b00;
    step_clk();
    chk("t3_halt_nopulse", 32'(oCpuEn), 32'd0);
    chk("t3_halt_idle", 32'(oState), 32'd0);

    // 4: FAST with breakpoint at 5, then one escaping step
    do_reset();
    iBreakEn = 1'b1; iBreakAddr = 8'h05; iPc = 8'h00; pc_auto = 1'b1; iMode = 2'b11;
    p0 = n_pulse;
    for (int i = 0; i < 40 && oState != 2'd2; i++) step_clk();
    chk("t4_break_state", 32'(oState), 32'd2);
    chk("t4_pulses", 32'(n_pulse - p0), 32'd5);
    chk("t4_pc", 32'(iPc), 32'h5);
    chk("t4_cnt", oStepCount, 32'd5);
    steps(10);
    chk("t4_held", 32'(n_pulse - p0), 32'd5);
    iStepBtn = 1'b0;
    for (int i = 0; i < 12 && oCpuEn !== 1'b1; i++) step_clk();
    chk("t4_esc_pulse", 32'(oCpuEn), 32'd1);
    chk("t4_esc_run", 32'(oState), 32'd1);
    chk("t4_esc_cnt", oStepCount, 32'd6);
    step_clk();
    chk("t4_pc_guard", 32'(oCpuEn), 32'd0);
    step_clk();
    chk("t4_resume", 32'(oCpuEn), 32'd1);
    iMode = 2'b00; iStepBtn = 1'b1;
    steps(10);
    pc_auto = 1'b0;

    // 5: halt request beats tick and breakpoint; only reset leaves DONE
    do_reset();
    iMode = 2'b11; iBreakEn = 1'b0; iPc = 8'h20; iLimit = 8'd0;
    steps(5);
    chk("t5_cnt_pre", oStepCount, 32'd4);
    iMode = 2'b10; iBreakEn = 1'b1; iBreakAddr = 8'h40;
    step_clk();
    chk("t5_guard", 32'(oCpuEn), 32'd0);
    iBreakAddr = 8'h20; iHaltReq = 1'b1;
    step_clk();
    chk("t5_done", 32'(oState), 32'd3);
    chk("t5_no_pulse", 32'(oCpuEn), 32'd0);
    chk("t5_cnt_hold", oStepCount, 32'd4);
    iHaltReq = 1'b0; iMode = 2'b11;
    steps(3);
    chk("t5_fast_ignored", 32'(oState), 32'd3);
    iMode = 2'b01;
    btn(1'b0, 8); btn(1'b1, 8);
    chk("t5_step_ignored", 32'(oState), 32'd3);
    chk("t5_cnt_still", oStepCount, 32'd4);
    iReset = 1'b0;
    step_clk();
    chk("t5_rst_state", 32'(oState), 32'd0);
    chk("t5_rst_cnt", oStepCount, 32'd0);
    iReset = 1'b1;

    // 6: reset mid-RUN and mid-debounce
    iMode = 2'b11; iBreakEn = 1'b0;
    steps(3);
    iStepBtn = 1'b0;
    steps(3);
    iReset = 1'b0; iMode = 2'b01;
    step_clk();
    chk("t6_en", 32'(oCpuEn), 32'd0);
    chk("t6_state", 32'(oState), 32'd0);
    chk("t6_cnt", oStepCount, 32'd0);
    iReset = 1'b1; iStepBtn = 1'b1;
    p0 = n_pulse;
    steps(10);
    chk("t6_no_stale_press", 32'(n_pulse - p0), 32'd0);
    btn(1'b0, 8); btn(1'b1, 8);
    chk("t6_fresh_press", 32'(n_pulse - p0), 32'd1);
    chk("t6_cnt_after", oStepCount, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
